// File: rtl/bus_tmo_bridge.sv
// bus_tmo_bridge
// Single-clock bridge from a system-bus master to one slave. Each accepted
// request is registered and sent downstream as a one-cycle strobe. The slave's
// ack, error and read data are returned to the master as a one-cycle
// response. If no ack arrives within TMO cycles, the bridge answers with an
// error. A master that raises both strobes at once gets an error response.
// A request that arrives while the bridge is busy is discarded and flagged.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   sys_addr_i/wdata_i/sel_i   master request payload
//   sys_wen_i, sys_ren_i       master write/read strobes (single-cycle)
//   sys_rdata_o/err_o/ack_o    response to master (valid while ack high)
//   addr_o/wdata_o/sel_o       slave payload, held until the next accept
//   wen_o, ren_o               slave strobes (one cycle)
//   rdata_i, err_i, ack_i      slave response
//   drop_o                     pulse: a request arrived while busy
//   tmo_clr_i, tmo_cnt_o       clear / saturating count of timeouts
`timescale 1ns/1ps
module bus_tmo_bridge #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   sys_addr_i,
  input  logic [DW-1:0]   sys_wdata_i,
  input  logic [DW/8-1:0] sys_sel_i,
  input  logic            sys_wen_i,
  input  logic            sys_ren_i,
  output logic [DW-1:0]   sys_rdata_o,
  output logic            sys_err_o,
  output logic            sys_ack_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] sel_o,
  output logic            wen_o,
  output logic            ren_o,
  input  logic [DW-1:0]   rdata_i,
  input  logic            err_i,
  input  logic            ack_i,
  output logic            drop_o,
  input  logic            tmo_clr_i,
  output logic [15:0]     tmo_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Last window cycle. The counter is 0 in ISSUE, so a timeout fires at TMO-1.
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t            state_q;
  logic [15:0]       wait_cnt_q;
  logic              is_read_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   sel_q;
  logic              wen_q;
  logic              ren_q;
  logic              ack_q;
  logic              err_q;
  logic [DW-1:0]     rdata_q;
  logic              drop_q;
  logic [15:0]       tmo_cnt_q;
  logic [15:0]       tmo_cnt_d;
  logic              expire_s;

  // A timeout is recorded only when no ack arrives in the last window cycle.
  assign expire_s = ((state_q == ISSUE) || (state_q == WAIT)) && !ack_i &&
                    (wait_cnt_q == TMO_LAST);

  // Main transaction FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= 16'd0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (sys_wen_i && sys_ren_i) begin
            // Collision: answer with an error; the slave is never touched.
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (sys_wen_i || sys_ren_i) begin
            state_q    <= ISSUE;
            addr_q     <= sys_addr_i;
            wdata_q    <= sys_wdata_i;
            sel_q      <= sys_sel_i;
            wen_q      <= sys_wen_i;
            ren_q      <= sys_ren_i;
            is_read_q  <= sys_ren_i;
            wait_cnt_q <= 16'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE, WAIT: begin
          drop_q <= sys_wen_i || sys_ren_i;
          if (ack_i) begin
            // An ack in the last window cycle still wins over the timeout.
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= err_i;
            rdata_q <= is_read_q ? rdata_i : '0;
          end else if (wait_cnt_q == TMO_LAST) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            state_q    <= WAIT;
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next value of the timeout event counter: clear wins, then saturating increment.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (tmo_clr_i) begin
      tmo_cnt_d = 16'd0;
    end else if (expire_s && (tmo_cnt_q != 16'hFFFF)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout event counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign sys_rdata_o = rdata_q;
  assign sys_err_o   = err_q;
  assign sys_ack_o   = ack_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign sel_o       = sel_q;
  assign wen_o       = wen_q;
  assign ren_o       = ren_q;
  assign drop_o      = drop_q;
  assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: tb/tb_bus_tmo_bridge.sv
`timescale 1ns/1ps
module tb_bus_tmo_bridge;

  localparam int TMO_M = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] sys_addr, sys_wdata, rdata_i;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, err_i, ack_i, tmo_clr;

  logic [31:0] sys_rdata, addr_o, wdata_o;
  logic [3:0]  sel_o;
  logic        sys_err, sys_ack, wen_o, ren_o, drop_o;
  logic [15:0] tmo_cnt;

  logic [31:0] a1_rdata, a1_addr, a1_wdata;
  logic [3:0]  a1_sel;
  logic        a1_err, a1_ack, a1_wen, a1_ren, a1_drop;
  logic [15:0] a1_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_tmo_bridge #(.AW(32), .DW(32), .TMO(TMO_M)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack),
    .addr_o(addr_o), .wdata_o(wdata_o), .sel_o(sel_o),
    .wen_o(wen_o), .ren_o(ren_o),
    .rdata_i(rdata_i), .err_i(err_i), .ack_i(ack_i),
    .drop_o(drop_o), .tmo_clr_i(tmo_clr), .tmo_cnt_o(tmo_cnt)
  );

  // Second instance for the TMO=1 boundary (ack accepted in ISSUE only).
  bus_tmo_bridge #(.AW(32), .DW(32), .TMO(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(a1_rdata), .sys_err_o(a1_err), .sys_ack_o(a1_ack),
    .addr_o(a1_addr), .wdata_o(a1_wdata), .sel_o(a1_sel),
    .wen_o(a1_wen), .ren_o(a1_ren),
    .rdata_i(rdata_i), .err_i(err_i), .ack_i(ack_i),
    .drop_o(a1_drop), .tmo_clr_i(tmo_clr), .tmo_cnt_o(a1_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sys_wen = 1'b0; sys_ren = 1'b0; ack_i = 1'b0; err_i = 1'b0;
    tmo_clr = 1'b0; rdata_i = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wen, ren, ack, err, clr;
    logic [31:0] rdata;
    logic        e_wen, e_ren, e_ack, e_err, e_drop;
    logic [31:0] e_rdata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic wen, input logic ren, input logic ack,
                              input logic err, input logic [31:0] rd, input logic clr,
                              input logic ew, input logic er, input logic ea,
                              input logic ee, input logic [31:0] erd, input logic ed,
                              input logic [15:0] ec);
    vec_t v;
    v.wen = wen; v.ren = ren; v.ack = ack; v.err = err; v.rdata = rd; v.clr = clr;
    v.e_wen = ew; v.e_ren = er; v.e_ack = ea; v.e_err = ee; v.e_rdata = erd;
    v.e_drop = ed; v.e_cnt = ec;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit          m_busy;
  int          m_age;
  bit          m_read;
  int unsigned m_cnt;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic        m_ack, m_err, m_wen, m_ren, m_drop;

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_read = 1'b0; m_cnt = 0;
    m_rdata = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_sel = 4'h0;
    m_ack = 1'b0; m_err = 1'b0; m_wen = 1'b0; m_ren = 1'b0; m_drop = 1'b0;
  endtask

  // Expected outputs after the coming clock edge, from the current inputs.
  task automatic model_step();
    m_ack = 1'b0; m_err = 1'b0; m_wen = 1'b0; m_ren = 1'b0; m_drop = 1'b0;
    if (m_busy) begin
      m_drop = sys_wen | sys_ren;
      if (ack_i) begin
        m_ack = 1'b1; m_err = err_i; m_rdata = m_read ? rdata_i : 32'h0; m_busy = 1'b0;
      end else if (m_age == TMO_M - 1) begin
        m_ack = 1'b1; m_err = 1'b1; m_rdata = 32'h0; m_busy = 1'b0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_age++;
      end
    end else if (sys_wen && sys_ren) begin
      m_ack = 1'b1; m_err = 1'b1; m_rdata = 32'h0;
    end else if (sys_wen || sys_ren) begin
      m_busy = 1'b1; m_age = 0; m_read = sys_ren;
      m_wen = sys_wen; m_ren = sys_ren;
      m_addr = sys_addr; m_wdata = sys_wdata; m_sel = sys_sel;
    end
    if (tmo_clr) m_cnt = 0;
  endtask

  task automatic timeout_run(input logic clr_last);
    sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    repeat (TMO_M - 1) @(negedge clk);
    tmo_clr = clr_last;
    @(negedge clk);
    tmo_clr = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    sys_addr = 32'h4000_0010; sys_wdata = 32'hA5A5_A5A5; sys_sel = 4'hC;
    #1;
    chk1("reset_ack", sys_ack, 1'b0);
    chk("reset_cnt", 32'(tmo_cnt), 32'h0);
    chk("reset_addr", addr_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    tbl[0]  = mk(0,1,0,0,32'h0,0,        0,1,0,0,32'h0,0,16'd0);
    tbl[1]  = mk(0,0,1,0,32'h12345678,0, 0,0,1,0,32'h12345678,0,16'd0);
    tbl[2]  = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h12345678,0,16'd0);
    tbl[3]  = mk(1,0,0,0,32'h0,0,        1,0,0,0,32'h12345678,0,16'd0);
    tbl[4]  = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h12345678,0,16'd0);
    tbl[5]  = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h12345678,0,16'd0);
    tbl[6]  = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h12345678,0,16'd0);
    tbl[7]  = mk(0,0,1,1,32'hDEADBEEF,0, 0,0,1,1,32'h0,0,16'd0);
    tbl[8]  = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd0);
    tbl[9]  = mk(0,1,0,0,32'h0,0,        0,1,0,0,32'h0,0,16'd0);
    tbl[10] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd0);
    tbl[11] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd0);
    tbl[12] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd0);
    tbl[13] = mk(0,0,0,0,32'h0,0,        0,0,1,1,32'h0,0,16'd1);
    tbl[14] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[15] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[16] = mk(0,0,1,0,32'h55555555,0, 0,0,0,0,32'h0,0,16'd1);
    tbl[17] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[18] = mk(0,1,0,0,32'h0,0,        0,1,0,0,32'h0,0,16'd1);
    tbl[19] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[20] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[21] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[22] = mk(0,0,1,0,32'hCAFEF00D,0, 0,0,1,0,32'hCAFEF00D,0,16'd1);
    tbl[23] = mk(1,1,0,0,32'h0,0,        0,0,1,1,32'h0,0,16'd1);
    tbl[24] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[25] = mk(0,1,0,0,32'h0,0,        0,1,0,0,32'h0,0,16'd1);
    tbl[26] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h0,0,16'd1);
    tbl[27] = mk(0,1,0,0,32'h0,0,        0,0,0,0,32'h0,1,16'd1);
    tbl[28] = mk(0,0,1,0,32'h00000011,0, 0,0,1,0,32'h00000011,0,16'd1);
    tbl[29] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h00000011,0,16'd1);
    tbl[30] = mk(0,0,0,0,32'h0,0,        0,0,0,0,32'h00000011,0,16'd1);
    tbl[31] = mk(0,0,0,0,32'h0,1,        0,0,0,0,32'h00000011,0,16'd0);

    for (int i = 0; i < 32; i++) begin
      sys_wen = tbl[i].wen; sys_ren = tbl[i].ren; ack_i = tbl[i].ack;
      err_i = tbl[i].err; rdata_i = tbl[i].rdata; tmo_clr = tbl[i].clr;
      @(negedge clk);
      chk1($sformatf("tbl%0d_wen", i), wen_o, tbl[i].e_wen);
      chk1($sformatf("tbl%0d_ren", i), ren_o, tbl[i].e_ren);
      chk1($sformatf("tbl%0d_ack", i), sys_ack, tbl[i].e_ack);
      chk1($sformatf("tbl%0d_err", i), sys_err, tbl[i].e_err);
      chk1($sformatf("tbl%0d_drop", i), drop_o, tbl[i].e_drop);
      chk($sformatf("tbl%0d_rdata", i), sys_rdata, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_cnt", i), 32'(tmo_cnt), 32'(tbl[i].e_cnt));
    end
    idle_inputs();
    chk("tbl_addr", addr_o, 32'h4000_0010);
    chk("tbl_wdata", wdata_o, 32'hA5A5_A5A5);
    chk("tbl_sel", 32'(sel_o), 32'hC);

    // Back-to-back reads: each new request accepted in RESP.
    for (int i = 0; i < 3; i++) begin
      sys_ren = 1'b1; ack_i = 1'b0; sys_addr = 32'h100 + 32'(i * 4);
      @(negedge clk);
      chk1($sformatf("b2b%0d_ren", i), ren_o, 1'b1);
      chk1($sformatf("b2b%0d_noack", i), sys_ack, 1'b0);
      chk($sformatf("b2b%0d_addr", i), addr_o, 32'h100 + 32'(i * 4));
      sys_ren = 1'b0; ack_i = 1'b1; rdata_i = 32'hA0 + 32'(i);
      @(negedge clk);
      chk1($sformatf("b2b%0d_ack", i), sys_ack, 1'b1);
      chk1($sformatf("b2b%0d_ren_lo", i), ren_o, 1'b0);
      chk($sformatf("b2b%0d_rdata", i), sys_rdata, 32'hA0 + 32'(i));
    end
    idle_inputs();
    @(negedge clk);

    // Counter saturation and clear priority.
    force dut.tmo_cnt_q = 16'hFFFE;
    #1;
    release dut.tmo_cnt_q;
    timeout_run(1'b0);
    chk1("sat1_ack", sys_ack, 1'b1);
    chk("sat1_cnt", 32'(tmo_cnt), 32'hFFFF);
    @(negedge clk);
    timeout_run(1'b0);
    chk1("sat2_err", sys_err, 1'b1);
    chk("sat2_cnt", 32'(tmo_cnt), 32'hFFFF);
    @(negedge clk);
    timeout_run(1'b1);
    chk1("clrprio_ack", sys_ack, 1'b1);
    chk("clrprio_cnt", 32'(tmo_cnt), 32'h0);
    @(negedge clk);

    // Reset asserted during WAIT.
    timeout_run(1'b0);
    @(negedge clk);
    sys_ren = 1'b1; sys_addr = 32'h1234_5670;
    @(negedge clk);
    sys_ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk1("rstw_ack", sys_ack, 1'b0);
    chk1("rstw_err", sys_err, 1'b0);
    chk1("rstw_ren", ren_o, 1'b0);
    chk("rstw_addr", addr_o, 32'h0);
    chk("rstw_wdata", wdata_o, 32'h0);
    chk("rstw_sel", 32'(sel_o), 32'h0);
    chk("rstw_cnt", 32'(tmo_cnt), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 2 * TMO_M; i++) begin
      @(negedge clk);
      chk1($sformatf("rstw_noack%0d", i), sys_ack, 1'b0);
    end

    // TMO=1: ack accepted only in ISSUE.
    do_reset();
    sys_ren = 1'b1; sys_addr = 32'h0000_0BAD; sys_wdata = 32'h7; sys_sel = 4'h3;
    @(negedge clk);
    chk1("t1_ren", a1_ren, 1'b1);
    chk1("t1_wen", a1_wen, 1'b0);
    chk("t1_addr", a1_addr, 32'h0000_0BAD);
    chk("t1_wdata", a1_wdata, 32'h7);
    chk("t1_sel", 32'(a1_sel), 32'h3);
    sys_ren = 1'b0;
    @(negedge clk);
    chk1("t1_tmo_ack", a1_ack, 1'b1);
    chk1("t1_tmo_err", a1_err, 1'b1);
    chk("t1_tmo_cnt", 32'(a1_cnt), 32'h1);
    sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0; ack_i = 1'b1; rdata_i = 32'h77;
    @(negedge clk);
    chk1("t1_ok_ack", a1_ack, 1'b1);
    chk1("t1_ok_err", a1_err, 1'b0);
    chk1("t1_ok_drop", a1_drop, 1'b0);
    chk("t1_ok_rdata", a1_rdata, 32'h77);
    chk("t1_ok_cnt", 32'(a1_cnt), 32'h1);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      sys_wen = 1'b0; sys_ren = 1'b0;
      if (r < 12) sys_wen = 1'b1;
      else if (r < 24) sys_ren = 1'b1;
      else if (r < 27) begin sys_wen = 1'b1; sys_ren = 1'b1; end
      ack_i = ($urandom_range(0, 3) == 0);
      err_i = 1'($urandom_range(0, 1));
      tmo_clr = ($urandom_range(0, 49) == 0);
      rdata_i = $urandom; sys_addr = $urandom; sys_wdata = $urandom;
      sys_sel = 4'($urandom);
      model_step();
      @(negedge clk);
      chk1("rnd_ack", sys_ack, m_ack);
      chk1("rnd_err", sys_err, m_err);
      chk1("rnd_wen", wen_o, m_wen);
      chk1("rnd_ren", ren_o, m_ren);
      chk1("rnd_drop", drop_o, m_drop);
      chk("rnd_rdata", sys_rdata, m_rdata);
      chk("rnd_addr", addr_o, m_addr);
      chk("rnd_wdata", wdata_o, m_wdata);
      chk("rnd_sel", 32'(sel_o), 32'(m_sel));
      chk("rnd_cnt", 32'(tmo_cnt), m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
